// File: rtl/musicbox_pkg.sv
// Shared constants and receiver state type for the music box DAC front end.
package musicbox_pkg;

    localparam int FRAME_BITS_DEFAULT = 16;
    localparam int DAC_DATA_W         = 12;
    localparam int PD_LSB             = 12;
    localparam int PD_MSB             = 13;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/spi_pin_synchronizer.sv
// Multi-flop synchronizer for one SPI pin, with falling-edge detect on the synchronized copy.
module spi_pin_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Flops reset high so an idle-high bus does not look like an edge at release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain[0] <= pin;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            prev <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign fall  = prev & ~chain[STAGES-1];

endmodule

// File: rtl/spi_dac_frame_receiver.sv
// Receives DAC write frames from an SPI master and republishes the 12-bit sample and power-down field.
module spi_dac_frame_receiver
    import musicbox_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock_50Mhz,
    input  logic                  reset,
    input  logic                  input_SPI_SCLK,
    input  logic                  input_SPI_SYNC_n,
    input  logic                  input_SPI_DIN,
    output logic [DAC_DATA_W-1:0] outputSample,
    output logic [1:0]            outputPowerDown,
    output logic                  sampleValid,
    output logic                  frameError,
    output logic                  isBusy,
    output logic [15:0]           frameCount
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int ARM_W = $clog2(SYNC_STAGES + 1);

    logic sclk_s, sclk_fall, syncn_s, din_s;
    logic unused_sclk_level, unused_syncn_fall, unused_din_fall, unused_hi;

    rx_state_e             state;
    logic [FRAME_BITS-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [ARM_W-1:0]      arm_cnt;
    logic                  arm_settled;
    logic                  frame_done;

    spi_pin_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clock_50Mhz), .rst(reset), .pin(input_SPI_SCLK),
        .level(unused_sclk_level), .fall(sclk_fall)
    );
    spi_pin_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_syncn (
        .clk(clock_50Mhz), .rst(reset), .pin(input_SPI_SYNC_n),
        .level(syncn_s), .fall(unused_syncn_fall)
    );
    spi_pin_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clk(clock_50Mhz), .rst(reset), .pin(input_SPI_DIN),
        .level(din_s), .fall(unused_din_fall)
    );

    assign sclk_s    = unused_sclk_level;
    assign unused_hi = ^shreg[FRAME_BITS-1:PD_MSB+1] ^ sclk_s;

    // The synchronizers come out of reset reading high regardless of the pins, so ARM
    // must not trust SYNC_n until the reset value has been flushed through them.
    assign arm_settled = (arm_cnt == ARM_W'(SYNC_STAGES));

    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            state      <= ST_ARM;
            arm_cnt    <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            frameError <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frameError <= 1'b0;
            if (!arm_settled) arm_cnt <= arm_cnt + ARM_W'(1);
            case (state)
                ST_ARM: begin
                    if (arm_settled && syncn_s) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!syncn_s) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    // SYNC_n high wins over a coincident edge: that edge is dropped.
                    if (syncn_s) begin
                        state      <= ST_IDLE;
                        frameError <= (bit_cnt != '0);
                    end else if (sclk_fall) begin
                        shreg   <= {shreg[FRAME_BITS-2:0], din_s};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            state      <= ST_HOLD;
                            frame_done <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (syncn_s) state <= ST_IDLE;
                end
                default: state <= ST_ARM;
            endcase
        end
    end

    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            outputSample    <= '0;
            outputPowerDown <= '0;
            sampleValid     <= 1'b0;
            frameCount      <= '0;
        end else begin
            sampleValid <= frame_done;
            if (frame_done) begin
                outputSample    <= shreg[DAC_DATA_W-1:0];
                outputPowerDown <= shreg[PD_MSB:PD_LSB];
                frameCount      <= frameCount + 16'd1;
            end
        end
    end

    assign isBusy = (state == ST_SHIFT);

endmodule

// File: tb/tb_spi_dac_frame_receiver.sv
// Randomized bench for spi_dac_frame_receiver against a frame-level reference model.
module tb_spi_dac_frame_receiver;

    localparam int FB = 16;
    localparam int SS = 2;

    logic        clk = 1'b0, rst = 1'b1, sclk = 1'b1, sync_n = 1'b1, din = 1'b0;
    logic [11:0] sample;
    logic [1:0]  pd;
    logic        valid, ferr, busy;
    logic [15:0] fcount;

    int checks = 0, errors = 0;
    int cyc = 0, n_valid = 0, n_err = 0, last_valid_cyc = 0, last_fall_cyc = 0;
    int base_v, base_e;

    logic [11:0] exp_sample = '0;
    logic [1:0]  exp_pd     = '0;
    logic [15:0] exp_count  = '0;
    int          exp_valid, exp_err;

    spi_dac_frame_receiver #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
        .clock_50Mhz(clk), .reset(rst),
        .input_SPI_SCLK(sclk), .input_SPI_SYNC_n(sync_n), .input_SPI_DIN(din),
        .outputSample(sample), .outputPowerDown(pd), .sampleValid(valid),
        .frameError(ferr), .isBusy(busy), .frameCount(fcount)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin n_valid++; last_valid_cyc = cyc; end
            if (ferr) n_err++;
        end
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    task automatic clock_bits(input logic [31:0] word, input int nbits, input int ht);
        for (int i = 0; i < nbits; i++) begin
            din = word[nbits-1-i];
            repeat (ht) @(negedge clk);
            sclk = 1'b0;
            last_fall_cyc = cyc;
            repeat (ht) @(negedge clk);
            sclk = 1'b1;
        end
    endtask

    task automatic send_window(input logic [31:0] word, input int nbits, input int ht);
        @(negedge clk);
        sync_n = 1'b0;
        repeat (ht) @(negedge clk);
        clock_bits(word, nbits, ht);
        repeat (ht) @(negedge clk);
        sync_n = 1'b1;
        repeat (SS + 6) @(negedge clk);
    endtask

    // Reference: first FB bits of a window form the frame; fewer than FB (but some) is an error.
    task automatic model_window(input logic [31:0] word, input int nbits);
        logic [31:0] f;
        if (nbits >= FB) begin
            f = word >> (nbits - FB);
            exp_sample = f[11:0];
            exp_pd     = f[13:12];
            exp_count  = exp_count + 16'd1;
            exp_valid  = 1;
            exp_err    = 0;
        end else begin
            exp_valid = 0;
            exp_err   = (nbits > 0) ? 1 : 0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (sample !== 12'h000) begin errors++; $display("FAIL reset_sample: got %h want 000", sample); end
        checks++; if (pd !== 2'b00) begin errors++; $display("FAIL reset_pd: got %b want 00", pd); end
        checks++; if (valid !== 1'b0 || ferr !== 1'b0) begin errors++; $display("FAIL reset_pulses: valid %b err %b want 0 0", valid, ferr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fcount !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h want 0000", fcount); end
        rst = 1'b0;
        repeat (SS + 6) @(negedge clk);
    endtask

    task automatic test_basic;
        base_v = n_valid; base_e = n_err;
        send_window(32'h1ABC, 16, 12);
        model_window(32'h1ABC, 16);
        checks++; if (n_valid - base_v != 1) begin errors++; $display("FAIL basic_valid: got %0d pulses want 1", n_valid - base_v); end
        checks++; if (n_err != base_e) begin errors++; $display("FAIL basic_err: got %0d pulses want 0", n_err - base_e); end
        checks++; if (sample !== 12'hABC) begin errors++; $display("FAIL basic_sample: got %h want abc", sample); end
        checks++; if (pd !== 2'b01) begin errors++; $display("FAIL basic_pd: got %b want 01", pd); end
        checks++; if (fcount !== 16'd1) begin errors++; $display("FAIL basic_count: got %h want 0001", fcount); end
        checks++; if (last_valid_cyc - last_fall_cyc != SS + 2) begin errors++; $display("FAIL basic_latency: got %0d want %0d", last_valid_cyc - last_fall_cyc, SS + 2); end
    endtask

    task automatic test_short;
        base_v = n_valid; base_e = n_err;
        send_window(32'h155, 9, 5);
        model_window(32'h155, 9);
        checks++; if (n_err - base_e != 1) begin errors++; $display("FAIL short_err: got %0d pulses want 1", n_err - base_e); end
        checks++; if (n_valid != base_v) begin errors++; $display("FAIL short_valid: got %0d pulses want 0", n_valid - base_v); end
        checks++; if (sample !== exp_sample) begin errors++; $display("FAIL short_sample: got %h want %h", sample, exp_sample); end
        checks++; if (fcount !== exp_count) begin errors++; $display("FAIL short_count: got %h want %h", fcount, exp_count); end
        send_window(32'h0FFF, 16, 4);
        model_window(32'h0FFF, 16);
        checks++; if (sample !== 12'hFFF) begin errors++; $display("FAIL short_next_sample: got %h want fff", sample); end
        checks++; if (pd !== 2'b00) begin errors++; $display("FAIL short_next_pd: got %b want 00", pd); end
    endtask

    task automatic test_long;
        base_v = n_valid; base_e = n_err;
        send_window(32'h2123A, 20, 4);
        model_window(32'h2123A, 20);
        checks++; if (n_valid - base_v != 1) begin errors++; $display("FAIL long_valid: got %0d pulses want 1", n_valid - base_v); end
        checks++; if (n_err != base_e) begin errors++; $display("FAIL long_err: got %0d pulses want 0", n_err - base_e); end
        checks++; if (sample !== 12'h123) begin errors++; $display("FAIL long_sample: got %h want 123", sample); end
        checks++; if (pd !== 2'b10) begin errors++; $display("FAIL long_pd: got %b want 10", pd); end
    endtask

    task automatic test_no_edges;
        int busy_cnt;
        busy_cnt = 0;
        base_v = n_valid; base_e = n_err;
        @(negedge clk);
        sync_n = 1'b0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (busy) busy_cnt++; end
        sync_n = 1'b1;
        for (int i = 0; i < SS + 6; i++) begin @(negedge clk); if (busy) busy_cnt++; end
        checks++; if (busy_cnt != 20) begin errors++; $display("FAIL idle_busy: got %0d busy cycles want 20", busy_cnt); end
        checks++; if (n_valid != base_v || n_err != base_e) begin errors++; $display("FAIL idle_pulses: got valid %0d err %0d want 0 0", n_valid - base_v, n_err - base_e); end
    endtask

    task automatic test_random;
        logic [31:0] w;
        int nb, ht;
        for (int k = 0; k < 25; k++) begin
            w  = $urandom;
            nb = $urandom_range(0, 20);
            ht = $urandom_range(SS + 1, 8);
            base_v = n_valid; base_e = n_err;
            send_window(w, nb, ht);
            model_window(w, nb);
            checks++; if (n_valid - base_v != exp_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %0d want %0d (nbits %0d)", k, n_valid - base_v, exp_valid, nb); end
            checks++; if (n_err - base_e != exp_err) begin errors++; $display("FAIL rand_err[%0d]: got %0d want %0d (nbits %0d)", k, n_err - base_e, exp_err, nb); end
            checks++; if (sample !== exp_sample || pd !== exp_pd) begin errors++; $display("FAIL rand_data[%0d]: got %h/%b want %h/%b", k, sample, pd, exp_sample, exp_pd); end
            checks++; if (fcount !== exp_count) begin errors++; $display("FAIL rand_count[%0d]: got %h want %h", k, fcount, exp_count); end
        end
    endtask

    task automatic test_reset_midframe;
        @(negedge clk);
        sync_n = 1'b0;
        repeat (4) @(negedge clk);
        clock_bits(32'hA5, 8, 4);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_sample = '0; exp_pd = '0; exp_count = '0;
        base_v = n_valid; base_e = n_err;
        repeat (6) @(negedge clk);
        clock_bits(32'h3456, 16, 4);
        repeat (10) @(negedge clk);
        checks++; if (n_valid != base_v || n_err != base_e) begin errors++; $display("FAIL arm_pulses: got valid %0d err %0d want 0 0", n_valid - base_v, n_err - base_e); end
        checks++; if (fcount !== 16'h0000 || sample !== 12'h000) begin errors++; $display("FAIL arm_outputs: got count %h sample %h want 0000 000", fcount, sample); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arm_busy: got %b want 0", busy); end
        sync_n = 1'b1;
        repeat (SS + 6) @(negedge clk);
        checks++; if (n_err != base_e) begin errors++; $display("FAIL arm_release_err: got %0d pulses want 0", n_err - base_e); end
        send_window(32'h2555, 16, 5);
        model_window(32'h2555, 16);
        checks++; if (sample !== exp_sample || pd !== exp_pd || fcount !== exp_count) begin errors++; $display("FAIL arm_next_frame: got %h/%b/%h want %h/%b/%h", sample, pd, fcount, exp_sample, exp_pd, exp_count); end
    endtask

    // Clocking 65,536 real frames would cost millions of cycles; preload the counter near the top.
    task automatic test_wrap;
        logic [31:0] w;
        @(negedge clk);
        force dut.frameCount = 16'hFFFE;
        @(negedge clk);
        release dut.frameCount;
        exp_count = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            w = $urandom & 32'hFFFF;
            send_window(w, 16, 3);
            model_window(w, 16);
            checks++; if (fcount !== exp_count) begin errors++; $display("FAIL wrap_count[%0d]: got %h want %h", k, fcount, exp_count); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_long();
        test_no_edges();
        test_random();
        test_reset_midframe();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_dac_frame_receiver.md
SPI_DAC_FRAME_RECEIVER -- requirements
Module: spi_dac_frame_receiver

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 16, SPI bits per DAC frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flop stages on each SPI pin input.
REQ-003 SHALL have port clock_50Mhz, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port input_SPI_SCLK, input, 1, DAC-side serial clock, asynchronous to clock_50Mhz.
REQ-006 SHALL have port input_SPI_SYNC_n, input, 1, frame select, active low.
REQ-007 SHALL have port input_SPI_DIN, input, 1, serial data, MSB first.
REQ-008 SHALL have port outputSample, output, 12, data bits [11:0] of the last good frame.
REQ-009 SHALL have port outputPowerDown, output, 2, frame bits [13:12] of the last good frame.
REQ-010 SHALL have port sampleValid, output, 1, one-cycle pulse per good frame.
REQ-011 SHALL have port frameError, output, 1, one-cycle pulse per short frame.
REQ-012 SHALL have port isBusy, output, 1, high while a frame is being shifted in.
REQ-013 SHALL have port frameCount, output, 16, count of good frames.

Function
REQ-014 SHALL pass SCLK, SYNC_n and DIN each through SYNC_STAGES flops and use only the synchronized copies.
REQ-015 SHALL detect an SCLK falling edge when the synchronized SCLK is 0 and its previous value was 1.
REQ-016 SHALL accept an edge only when the synchronized SYNC_n is 0 in the same cycle, and SHALL then shift the synchronized DIN into a FRAME_BITS shift register LSB-ward.
REQ-017 SHALL implement the states ARM, IDLE, SHIFT and HOLD.
REQ-018 ARM SHALL go to IDLE on synchronized SYNC_n high.
REQ-019 IDLE SHALL go to SHIFT on synchronized SYNC_n low, clearing the bit counter.
REQ-020 SHIFT SHALL go to HOLD on the FRAME_BITS-th accepted edge.
REQ-021 SHIFT SHALL go to IDLE on SYNC_n high before FRAME_BITS edges.
REQ-022 HOLD SHALL go to IDLE on SYNC_n high.
REQ-023 On the FRAME_BITS-th edge, SHALL on the next cycle update outputSample and outputPowerDown, pulse sampleValid high for exactly 1 cycle, and increment frameCount.
REQ-024 Total latency from the pin-level SCLK falling edge to sampleValid high SHALL be SYNC_STAGES+2 cycles.
REQ-025 frameCount SHALL wrap 0xFFFF -> 0x0000 with no flag.
REQ-026 SYNC_n rising with 1..FRAME_BITS-1 bits received SHALL pulse frameError for 1 cycle; outputs and frameCount SHALL be unchanged and the partial data discarded.
REQ-027 A SYNC_n low pulse with 0 bits received SHALL be ignored silently, with no error.
REQ-028 SCLK edges in HOLD or IDLE SHALL be ignored, with no effect on any output.
REQ-029 If SYNC_n rises in the same cycle as a detected edge, the edge SHALL be rejected per REQ-016 and REQ-026 SHALL apply.
REQ-030 isBusy SHALL be 1 exactly in SHIFT.
REQ-031 outputSample and outputPowerDown SHALL hold their value between frames.
REQ-032 Supported SCLK high and low times SHALL each be at least SYNC_STAGES+1 clock periods; behaviour below that is unspecified.

Reset
REQ-033 While reset=1: state=ARM, all synchronizer flops =1, shift register and bit counter =0, outputSample=0, outputPowerDown=0, sampleValid=0, frameError=0, isBusy=0, frameCount=0.
REQ-034 A frame in progress at reset SHALL be discarded without frameError.
REQ-035 After release, no frame SHALL be accepted until SYNC_n has been observed high (ARM state).

Structure
REQ-036 FRAME_BITS default, DAC data width 12, power-down field position [13:12] and the state enum typedef SHALL live in shared package musicbox_pkg.
REQ-037 The synchronizer and falling-edge detect SHALL be one sub-module, spi_pin_synchronizer, instantiated three times (falling-edge output used for SCLK only).

Verification
REQ-038 Frame 0x1ABC, SCLK 2 MHz -> sampleValid once, outputSample=0xABC, outputPowerDown=2'b01, frameCount=1, latency 4 cycles.
REQ-039 SYNC_n high after 9 bits -> frameError one pulse, outputSample unchanged, frameCount unchanged; next frame 0x0FFF -> outputSample=0xFFF.
REQ-040 20 SCLK edges in one SYNC_n window with the first 16 bits = 0x2123 -> single sampleValid, outputSample=0x123, extra edges ignored.
REQ-041 Reset asserted after bit 8 with SYNC_n held low through release -> no valid and no error until SYNC_n goes high; the next full frame is accepted.
REQ-042 65,536 good frames -> frameCount returns to 0x0000.
REQ-043 SYNC_n low/high with no SCLK edges -> no sampleValid, no frameError, isBusy high only during the low window (offset by the synchronizer delay).
